// File: rtl/wave_fifo_writer.sv
// Write-side producer for the async sample FIFO (wclk domain).
// On a start pulse it emits a programmed burst of ramp, triangle, square or
// constant samples into the FIFO write port, stalling on wfull.
//
// Handshake: wr is the valid, ~wfull is the ready. A sample is transferred
// on every wclk edge where wr is high; wr is never raised while wfull is high,
// and wdata only advances on a transfer, so a stalled sample simply waits.
module wave_fifo_writer #(
    parameter int P_NBIT_D = 16,
    parameter int P_NBIT_N = 16
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          cfg_mode,
    input  logic [P_NBIT_D-1:0] cfg_min,
    input  logic [P_NBIT_D-1:0] cfg_max,
    input  logic [P_NBIT_D-1:0] cfg_step,
    input  logic [P_NBIT_N-1:0] cfg_len,
    input  logic                wfull,
    output logic                wr,
    output logic [P_NBIT_D-1:0] wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                fsm_state
);

    localparam int W = P_NBIT_D + 1;
    localparam logic [W-1:0] ONE_W = W'(1);

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_TRI   = 2'd1;
    localparam logic [1:0] MODE_SQR   = 2'd2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [1:0]          mode_q;
    logic [P_NBIT_D-1:0] min_q;
    logic [P_NBIT_D-1:0] max_q;
    logic [P_NBIT_D-1:0] step_q;
    logic [P_NBIT_N-1:0] remaining;
    // Triangle: 1 = heading down. Square: 1 = currently at max.
    logic                phase;
    logic [P_NBIT_D-1:0] hold_cnt;

    logic                cfg_bad;
    logic                accept;
    logic [W-1:0]        sum;
    logic [W-1:0]        min_plus_step;
    logic [W-1:0]        hold_inc;
    logic [P_NBIT_D-1:0] next_sample;
    logic                next_phase;
    logic [P_NBIT_D-1:0] next_hold;

    assign busy      = (state == S_RUN);
    assign wr        = busy & ~wfull;
    assign accept    = wr;
    assign fsm_state = (state == S_RUN);

    // A start request is rejected when the burst would be empty, the bounds
    // are inverted, or a non-constant waveform would never advance.
    assign cfg_bad = (cfg_len == '0) || (cfg_min > cfg_max) ||
                     ((cfg_step == '0) && (cfg_mode != 2'd3));

    // Next sample computed one bit wider than the data so nothing wraps.
    always_comb begin
        sum           = {1'b0, wdata} + {1'b0, step_q};
        min_plus_step = {1'b0, min_q} + {1'b0, step_q};
        hold_inc      = {1'b0, hold_cnt} + ONE_W;
        next_sample   = wdata;
        next_phase    = phase;
        next_hold     = hold_cnt;
        case (mode_q)
            MODE_RAMP: begin
                if (sum > {1'b0, max_q}) begin
                    next_sample = min_q;
                end else begin
                    next_sample = sum[P_NBIT_D-1:0];
                end
            end
            MODE_TRI: begin
                if (!phase) begin
                    if (sum >= {1'b0, max_q}) begin
                        next_sample = max_q;
                        next_phase  = 1'b1;
                    end else begin
                        next_sample = sum[P_NBIT_D-1:0];
                    end
                end else begin
                    if ({1'b0, wdata} < min_plus_step) begin
                        next_sample = min_q;
                        next_phase  = 1'b0;
                    end else begin
                        next_sample = wdata - step_q;
                    end
                end
            end
            MODE_SQR: begin
                if (hold_inc >= {1'b0, step_q}) begin
                    next_hold   = '0;
                    next_phase  = ~phase;
                    next_sample = phase ? min_q : max_q;
                end else begin
                    next_hold   = hold_inc[P_NBIT_D-1:0];
                end
            end
            default: begin
                next_sample = min_q;
            end
        endcase
    end

    // Burst control FSM with registered data, counters and status pulses.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            min_q     <= '0;
            max_q     <= '0;
            step_q    <= '0;
            remaining <= '0;
            phase     <= 1'b0;
            hold_cnt  <= '0;
            wdata     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            mode_q    <= cfg_mode;
                            min_q     <= cfg_min;
                            max_q     <= cfg_max;
                            step_q    <= cfg_step;
                            remaining <= cfg_len;
                            wdata     <= cfg_min;
                            phase     <= 1'b0;
                            hold_cnt  <= '0;
                            state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // The write presented this cycle is taken even if aborting.
                    if (accept) begin
                        wdata     <= next_sample;
                        remaining <= remaining - P_NBIT_N'(1);
                        phase     <= next_phase;
                        hold_cnt  <= next_hold;
                    end
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (accept && (remaining == P_NBIT_N'(1))) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
